// File: rtl/fc_w_pkg.sv
// Shared constants and FSM state type for the FC weight BRAM loader.
package fc_w_pkg;
   localparam int FC_W_DATA_W         = 32;
   localparam int FC_W_WORDS_PER_LINE = 30;
   localparam int FC_W_LINE_W         = 960;
   localparam int FC_W_ADDR_W         = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } fc_w_state_t;
endpackage

// File: rtl/fc_w_bram_loader_if.sv
// Word stream from the host data mover plus the BRAM write port it feeds.
interface fc_w_bram_loader_if
   import fc_w_pkg::*;
#(
   parameter int DATA_W = FC_W_DATA_W,
   parameter int LINE_W = FC_W_LINE_W,
   parameter int ADDR_W = FC_W_ADDR_W
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [LINE_W-1:0] bram_din;

   modport master (
      output s_data, s_valid,
      input  s_ready, bram_we, bram_addr, bram_din
   );

   modport slave (
      input  s_data, s_valid,
      output s_ready, bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/fc_w_line_packer.sv
// Word counter and packing register; word k of a line lands in bits [k*DATA_W +: DATA_W].
module fc_w_line_packer
   import fc_w_pkg::*;
#(
   parameter int DATA_W         = FC_W_DATA_W,
   parameter int WORDS_PER_LINE = FC_W_WORDS_PER_LINE,
   parameter int LINE_W         = FC_W_LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_word,
   output logic [LINE_W-1:0] o_line_nxt,
   output logic              o_line_full
);
   localparam int CNT_W = $clog2(WORDS_PER_LINE);

   logic [CNT_W-1:0]  r_cnt;
   logic [LINE_W-1:0] r_line;

   // o_line_nxt already holds the word being accepted, so the top can capture a full line
   always_comb begin
      o_line_nxt = r_line;
      o_line_nxt[r_cnt*DATA_W +: DATA_W] = i_word;
   end

   assign o_line_full = i_push && (r_cnt == CNT_W'(WORDS_PER_LINE - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_cnt  <= '0;
         r_line <= '0;
      end else if (i_push) begin
         r_line <= o_line_nxt;
         r_cnt  <= o_line_full ? '0 : r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/fc_w_bram_loader.sv
// Packs 30-word groups into 960-bit lines and writes them to BRAM from address 0.
// Optional FC_W_LOADER_CHECKSUM_EN adds chk_sum, the mod-2^32 sum of accepted words.
module fc_w_bram_loader
   import fc_w_pkg::*;
#(
   parameter int DATA_W         = FC_W_DATA_W,
   parameter int WORDS_PER_LINE = FC_W_WORDS_PER_LINE,
   parameter int LINE_W         = FC_W_LINE_W,
   parameter int ADDR_W         = FC_W_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   cfg_num_lines,
   fc_w_bram_loader_if.slave bus,
   output logic              busy,
   output logic              done
`ifdef FC_W_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]       chk_sum
`endif
);
   localparam logic [ADDR_W:0] MAX_LINES = {1'b1, {ADDR_W{1'b0}}};

   function automatic logic [ADDR_W:0] sat_lines(input logic [ADDR_W:0] n);
      return (n > MAX_LINES) ? MAX_LINES : n;
   endfunction

   fc_w_state_t       r_state, w_state_nxt;
   logic [ADDR_W:0]   r_num_lines, r_line_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_din;
   logic              w_accept, w_start_ok, w_line_full, w_last_line;
   logic [ADDR_W:0]   w_line_cnt_inc;
   logic [LINE_W-1:0] w_line_nxt;

   assign w_accept       = bus.s_valid && bus.s_ready;
   assign w_start_ok     = (r_state == IDLE) && start;
   assign w_line_cnt_inc = r_line_cnt + 1'b1;
   assign w_last_line    = (w_line_cnt_inc == r_num_lines);

   fc_w_line_packer #(
      .DATA_W         (DATA_W),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .LINE_W         (LINE_W)
   ) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (w_start_ok),
      .i_push      (w_accept),
      .i_word      (bus.s_data),
      .o_line_nxt  (w_line_nxt),
      .o_line_full (w_line_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      bus.s_ready = 1'b0;
      bus.bram_we = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = (cfg_num_lines == '0) ? DONE : FILL;
         end
         FILL: begin
            bus.s_ready = 1'b1;
            busy        = 1'b1;
            if (w_line_full) w_state_nxt = WRITE;
         end
         WRITE: begin
            bus.bram_we = 1'b1;
            busy        = 1'b1;
            w_state_nxt = w_last_line ? DONE : FILL;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address and line are captured as the last word is accepted, then held until the next line
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_num_lines <= '0;
         r_line_cnt  <= '0;
         r_addr      <= '0;
         r_din       <= '0;
      end else begin
         if (w_start_ok) begin
            r_num_lines <= sat_lines(cfg_num_lines);
            r_line_cnt  <= '0;
         end else if (r_state == WRITE) begin
            r_line_cnt  <= w_line_cnt_inc;
         end
         if (w_line_full) begin
            r_addr <= r_line_cnt[ADDR_W-1:0];
            r_din  <= w_line_nxt;
         end
      end
   end

   assign bus.bram_addr = r_addr;
   assign bus.bram_din  = r_din;

`ifdef FC_W_LOADER_CHECKSUM_EN
   logic [31:0] r_chk;

   always_ff @(posedge clk) begin
      if (!rst_n || w_start_ok) r_chk <= '0;
      else if (w_accept)        r_chk <= r_chk + 32'(bus.s_data);
   end

   assign chk_sum = r_chk;
`endif
endmodule

// File: tb/tb_fc_w_bram_loader.sv
// Randomized scoreboard bench for fc_w_bram_loader; expected BRAM lines come from a word-list model.
`timescale 1ns/1ps
module tb_fc_w_bram_loader;
   localparam int DW  = 32;
   localparam int WPL = 30;
   localparam int LW  = 960;
   localparam int AW  = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   cfg = '0;
   logic          busy, done;
`ifdef FC_W_LOADER_CHECKSUM_EN
   logic [31:0]   chk_sum;
`endif

   fc_w_bram_loader_if #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW)) bus ();

   fc_w_bram_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_num_lines (cfg),
      .bus           (bus),
      .busy          (busy),
      .done          (done)
`ifdef FC_W_LOADER_CHECKSUM_EN
      ,
      .chk_sum       (chk_sum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int            addr;
      logic [LW-1:0] line;
   } wr_t;

   int            total = 0;
   int            bad = 0;
   int            n_writes = 0;
   int            last_addr = -1;
   logic [LW-1:0] last_din = '0;
   wr_t           exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_line(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         for (int k = 0; k < WPL; k++) begin
            if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
               $display("FAIL %s word %0d: got %h want %h", nm, k, act[k*DW +: DW], exp[k*DW +: DW]);
               break;
            end
         end
      end
   endtask

   // Monitor: every BRAM write is popped against the scoreboard
   always @(negedge clk) begin
      wr_t e;
      if (rst_n && bus.bram_we) begin
         n_writes++;
         last_addr = int'(bus.bram_addr);
         last_din  = bus.bram_din;
         chk("ready_low_in_write", 64'(bus.s_ready), 64'd0);
         chk("busy_in_write", 64'(busy), 64'd1);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0d want no write", bus.bram_addr);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", 64'(bus.bram_addr), 64'(e.addr));
            chk_line("write_line", bus.bram_din, e.line);
         end
      end
   end

   // One load session; abort_after>=0 resets after that many accepted words
   task automatic run_session(input int cfg_lines, input int gap_pct, input bit incr,
                              input int stray_start_at, input int abort_after);
      int            eff;
      int            gidx;
      int            guard;
      int            wcnt;
      int            base_writes;
      bit            have;
      logic [DW-1:0] w;
      logic [31:0]   sum;
      logic [LW-1:0] line;
      logic [DW-1:0] words[$];
      wr_t           e;

      eff         = (cfg_lines > 1024) ? 1024 : cfg_lines;
      gidx        = 0;
      have        = 1'b0;
      w           = '0;
      sum         = '0;
      base_writes = n_writes;

      @(posedge clk); #1;
      start = 1'b1;
      cfg   = (AW+1)'(cfg_lines);
      @(posedge clk); #1;
      start = 1'b0;

      if (eff == 0) begin
         @(negedge clk);
         chk("zero_done", 64'(done), 64'd1);
         chk("zero_busy", 64'(busy), 64'd0);
         @(negedge clk);
         chk("zero_done_pulse", 64'(done), 64'd0);
         chk("zero_no_write", 64'(n_writes - base_writes), 64'd0);
         return;
      end

      for (int ln = 0; ln < eff; ln++) begin
         words.delete();
         guard = 0;
         while (words.size() < WPL) begin
            if (abort_after >= 0 && gidx == abort_after) begin
               rst_n       = 1'b0;
               bus.s_valid = 1'b0;
               @(posedge clk); #1;
               @(negedge clk);
               chk("abort_busy", 64'(busy), 64'd0);
               chk("abort_done", 64'(done), 64'd0);
               chk("abort_we", 64'(bus.bram_we), 64'd0);
               chk("abort_ready", 64'(bus.s_ready), 64'd0);
               chk("abort_addr", 64'(bus.bram_addr), 64'd0);
               chk_line("abort_din", bus.bram_din, '0);
`ifdef FC_W_LOADER_CHECKSUM_EN
               chk("abort_chk_sum", 64'(chk_sum), 64'd0);
`endif
               @(posedge clk); #1;
               rst_n = 1'b1;
               for (int c = 0; c < 6; c++) begin
                  @(negedge clk);
                  chk("abort_no_done", 64'(done), 64'd0);
               end
               chk("abort_no_write", 64'(n_writes - base_writes), 64'(ln));
               chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
               return;
            end
            if (!have) begin
               w    = incr ? DW'(gidx + 1) : DW'($urandom());
               have = 1'b1;
            end
            bus.s_valid = ($urandom_range(99) >= gap_pct);
            bus.s_data  = w;
            if (stray_start_at == gidx) begin
               start = 1'b1;
               cfg   = (AW+1)'(5);
            end
            @(negedge clk);
            chk("busy_in_session", 64'(busy), 64'd1);
            if (bus.s_valid && bus.s_ready) begin
               words.push_back(w);
               sum  = sum + w;
               gidx++;
               have = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (guard > 400) begin
               total++;
               bad++;
               $display("FAIL word_timeout: got %0d words want %0d", words.size(), WPL);
               bus.s_valid = 1'b0;
               return;
            end
         end
         line = '0;
         foreach (words[k]) line[k*DW +: DW] = words[k];
         e.addr = ln;
         e.line = line;
         exp_q.push_back(e);
      end
      bus.s_valid = 1'b0;

      wcnt = 0;
      do begin
         @(negedge clk);
         wcnt++;
      end while (!done && wcnt < 20);
      chk("done_latency", 64'(wcnt), 64'd2);
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("write_count", 64'(n_writes - base_writes), 64'(eff));
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef FC_W_LOADER_CHECKSUM_EN
      chk("chk_sum_at_done", 64'(chk_sum), 64'(sum));
`endif
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      // Reset then idle
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(bus.s_ready), 64'd0);
      chk("rst_we", 64'(bus.bram_we), 64'd0);
      chk("rst_addr", 64'(bus.bram_addr), 64'd0);
      chk_line("rst_din", bus.bram_din, '0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hDEADBEEF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("idle_ready_low", 64'(bus.s_ready), 64'd0);
      end
      bus.s_valid = 1'b0;
      chk("idle_no_write", 64'(n_writes), 64'd0);

      // Single line of words 1..30
      run_session(1, 0, 1'b1, -1, -1);
      chk("single_addr", 64'(last_addr), 64'd0);
      chk("single_first_word", 64'(last_din[31:0]), 64'h1);
      chk("single_last_word", 64'(last_din[959:928]), 64'h1E);
`ifdef FC_W_LOADER_CHECKSUM_EN
      chk("single_chk_sum", 64'(chk_sum), 64'd465);
`endif

      // Multi-line with random gaps
      run_session(3, 35, 1'b0, -1, -1);
      chk("multi_last_addr", 64'(last_addr), 64'd2);

      // Zero lines, then a stray start during a 2-line session
      run_session(0, 0, 1'b0, -1, -1);
      run_session(2, 10, 1'b0, 10, -1);
      chk("stray_last_addr", 64'(last_addr), 64'd1);

      // Reset after 15 words of line 1
      run_session(2, 20, 1'b0, -1, 45);

      // Full depth and saturation
      run_session(1024, 0, 1'b0, -1, -1);
      chk("full_last_addr", 64'(last_addr), 64'd1023);
      run_session(2047, 0, 1'b0, -1, -1);
      chk("sat_last_addr", 64'(last_addr), 64'd1023);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
